// File: rtl/qracc_pkg.sv
// Shared definitions for the QR accelerator sequencer and its macro model:
// array geometry defaults and the sequencer state encoding.
package qracc_pkg;

   localparam int NUM_ROWS     = 128;
   localparam int NUM_COLS     = 8;
   localparam int NUM_ADC_BITS = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_DRIVE = 3'd2;
   localparam logic [2:0] ST_CONV  = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      PRE   = ST_PRE,
      DRIVE = ST_DRIVE,
      CONV  = ST_CONV,
      OUT   = ST_OUT
   } qracc_state_e;

endpackage

// File: rtl/qracc_drv_decode.sv
// Combinational decode of sequencer state and activation vector into the
// macro's row switch selects and ADC phase controls, with their complements.
module qracc_drv_decode
   import qracc_pkg::*;
#(
   parameter int numRows = NUM_ROWS,
   parameter int numCols = NUM_COLS
)(
   input  qracc_state_e       state,
   input  logic [numRows-1:0] act,
   output logic [numRows-1:0] vdr_sel,
   output logic [numRows-1:0] vss_sel,
   output logic [numRows-1:0] vrst_sel,
   output logic [numRows-1:0] vdr_selb,
   output logic [numRows-1:0] vss_selb,
   output logic [numRows-1:0] vrst_selb,
   output logic [numCols-1:0] nf,
   output logic [numCols-1:0] m2a,
   output logic [numCols-1:0] r2a,
   output logic [numCols-1:0] nfb,
   output logic [numCols-1:0] m2ab,
   output logic [numCols-1:0] r2ab
);

   always_comb begin
      // Safe pattern: every row tied to VSS, ADC idle.
      vdr_sel  = '0;
      vss_sel  = '1;
      vrst_sel = '0;
      nf       = '0;
      m2a      = '0;
      r2a      = '0;
      case (state)
         PRE: begin
            vss_sel  = '0;
            vrst_sel = '1;
            r2a      = '1;
         end
         DRIVE: begin
            vdr_sel = act;
            vss_sel = ~act;
            m2a     = '1;
         end
         CONV: begin
            vdr_sel = act;
            vss_sel = ~act;
            m2a     = '1;
            nf      = '1;
         end
         default: begin
         end
      endcase
   end

   assign vdr_selb  = ~vdr_sel;
   assign vss_selb  = ~vss_sel;
   assign vrst_selb = ~vrst_sel;
   assign nfb       = ~nf;
   assign m2ab      = ~m2a;
   assign r2ab      = ~r2a;

endmodule

// File: rtl/qracc_mac_seq.sv
// Compute sequencer for the QR accelerator macro: accepts an activation vector,
// runs reset / drive-settle / convert phases, and returns the captured ADC word.
module qracc_mac_seq
   import qracc_pkg::*;
#(
   parameter int numRows      = NUM_ROWS,
   parameter int numCols      = NUM_COLS,
   parameter int numAdcBits   = NUM_ADC_BITS,
   parameter int settleCycles = 2
)(
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [numRows-1:0]            in_act,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [numAdcBits*numCols-1:0] out_data,
   output logic                          busy,
   input  logic [numAdcBits*numCols-1:0] ADC_OUT,
   output logic [numRows-1:0]            VDR_SEL,
   output logic [numRows-1:0]            VSS_SEL,
   output logic [numRows-1:0]            VRST_SEL,
   output logic [numRows-1:0]            VDR_SELB,
   output logic [numRows-1:0]            VSS_SELB,
   output logic [numRows-1:0]            VRST_SELB,
   output logic [numCols-1:0]            NF,
   output logic [numCols-1:0]            M2A,
   output logic [numCols-1:0]            R2A,
   output logic [numCols-1:0]            NFB,
   output logic [numCols-1:0]            M2AB,
   output logic [numCols-1:0]            R2AB
);

   localparam logic [3:0] SETTLE_LAST = 4'(settleCycles - 1);

   qracc_state_e                   state_reg, state_next;
   logic [3:0]                     cnt_reg, cnt_next;
   logic [numRows-1:0]             act_reg, act_next;
   logic [numAdcBits*numCols-1:0]  data_reg;

   qracc_state_e                   dec_state;
   logic [numRows-1:0]             dec_act;
   logic [numRows-1:0]             vdr_next, vss_next, vrst_next;
   logic [numRows-1:0]             vdrb_next, vssb_next, vrstb_next;
   logic [numCols-1:0]             nf_next, m2a_next, r2a_next;
   logic [numCols-1:0]             nfb_next, m2ab_next, r2ab_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      act_next   = act_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               act_next   = in_act;
               state_next = PRE;
            end
         end
         PRE: begin
            cnt_next   = '0;
            state_next = DRIVE;
         end
         DRIVE: begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == SETTLE_LAST) state_next = CONV;
         end
         CONV:    state_next = OUT;
         OUT:     if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         act_reg   <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         act_reg   <= act_next;
         if (state_reg == CONV) data_reg <= ADC_OUT;
      end
   end

   // Reset steers the decoder to IDLE so the drive registers load the safe
   // pattern (with consistent complements) on every reset edge.
   assign dec_state = nRST ? state_next : IDLE;
   assign dec_act   = nRST ? act_next : '0;

   qracc_drv_decode #(
      .numRows (numRows),
      .numCols (numCols)
   ) u_decode (
      .state     (dec_state),
      .act       (dec_act),
      .vdr_sel   (vdr_next),
      .vss_sel   (vss_next),
      .vrst_sel  (vrst_next),
      .vdr_selb  (vdrb_next),
      .vss_selb  (vssb_next),
      .vrst_selb (vrstb_next),
      .nf        (nf_next),
      .m2a       (m2a_next),
      .r2a       (r2a_next),
      .nfb       (nfb_next),
      .m2ab      (m2ab_next),
      .r2ab      (r2ab_next)
   );

   always_ff @(posedge CLK) begin
      VDR_SEL   <= vdr_next;
      VSS_SEL   <= vss_next;
      VRST_SEL  <= vrst_next;
      VDR_SELB  <= vdrb_next;
      VSS_SELB  <= vssb_next;
      VRST_SELB <= vrstb_next;
      NF        <= nf_next;
      M2A       <= m2a_next;
      R2A       <= r2a_next;
      NFB       <= nfb_next;
      M2AB      <= m2ab_next;
      R2AB      <= r2ab_next;
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == OUT);
   assign busy      = (state_reg != IDLE);
   assign out_data  = data_reg;

endmodule
